// File: rtl/pipe_pkg.sv
// Shared encodings and default widths for the 5-stage core pipeline blocks.
package pipe_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_ALU_OP_W   = 4;
  localparam int DEF_CNT_W      = 32;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [4:0] REG_RA = 5'd31;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection: a load in EX whose destination is read by the
// instruction in ID forces a one-cycle stall unless that instruction is flushed.
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  ex_valid_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_write_register_i,
  input  logic                  id_valid_i,
  input  logic                  id_uses_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic                  id_uses_rt_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  flush_i,
  input  logic                  stall_ext_i,
  output logic                  load_use_stall_o,
  output logic                  pc_write_o,
  output logic                  if_id_write_o
);

  logic src_match;
  logic haz;

  assign src_match = (id_uses_rs_i && (id_rs_i == ex_write_register_i)) ||
                     (id_uses_rt_i && (id_rt_i == ex_write_register_i));

  assign haz = ex_valid_i && ex_mem_read_i && (ex_write_register_i != '0) &&
               src_match && id_valid_i;

  // A flushed ID instruction is discarded anyway, so it never needs to wait.
  assign load_use_stall_o = haz && !flush_i;
  assign pc_write_o       = !stall_ext_i && !load_use_stall_o;
  assign if_id_write_o    = !stall_ext_i && !load_use_stall_o;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion (flush / load-use), external
// freeze, and saturating stall/bubble performance counters.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int ALU_OP_W   = DEF_ALU_OP_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_stall_ext,
  input  logic                  i_flush,
  input  logic                  i_id_valid,
  input  logic [DATA_W-1:0]     i_id_pc,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_id_uses_rs,
  input  logic                  i_id_uses_rt,
  input  logic [DATA_W-1:0]     i_id_rs_data,
  input  logic [DATA_W-1:0]     i_id_rt_data,
  input  logic [DATA_W-1:0]     i_id_imm,
  input  logic [ALU_OP_W-1:0]   i_id_alu_op,
  input  logic                  i_id_alu_src,
  input  logic [1:0]            i_id_reg_dst,
  input  logic                  i_id_reg_write,
  input  logic                  i_id_mem_read,
  input  logic                  i_id_mem_write,
  input  logic                  i_id_mem_to_reg,
  output logic                  o_ex_valid,
  output logic [DATA_W-1:0]     o_ex_pc,
  output logic [REG_ADDR_W-1:0] o_ex_rs,
  output logic [REG_ADDR_W-1:0] o_ex_rt,
  output logic [DATA_W-1:0]     o_ex_rs_data,
  output logic [DATA_W-1:0]     o_ex_rt_data,
  output logic [DATA_W-1:0]     o_ex_imm,
  output logic [ALU_OP_W-1:0]   o_ex_alu_op,
  output logic                  o_ex_alu_src,
  output logic                  o_ex_reg_write,
  output logic                  o_ex_mem_read,
  output logic                  o_ex_mem_write,
  output logic                  o_ex_mem_to_reg,
  output logic [REG_ADDR_W-1:0] o_ex_write_register,
  output logic                  o_load_use_stall,
  output logic                  o_pc_write,
  output logic                  o_if_id_write,
  output logic [CNT_W-1:0]      o_stall_count,
  output logic [CNT_W-1:0]      o_bubble_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  // A non-writing instruction gets destination 0 so it can never forward.
  function automatic logic [REG_ADDR_W-1:0] resolve_wr(
    input logic [1:0]            dst,
    input logic [REG_ADDR_W-1:0] rt,
    input logic [REG_ADDR_W-1:0] rd,
    input logic                  wr_en
  );
    if (!wr_en)                 return '0;
    else if (dst == REG_DST_RD) return rd;
    else if (dst == REG_DST_RA) return REG_ADDR_W'(REG_RA);
    else                        return rt;
  endfunction

  logic                  valid_q, valid_d;
  logic [DATA_W-1:0]     pc_q, pc_d, rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic [REG_ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, wr_q, wr_d;
  logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d;
  logic                  alu_src_q, alu_src_d, reg_write_q, reg_write_d;
  logic                  mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic                  mem_to_reg_q, mem_to_reg_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;
  logic                  bubble;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_detect (
    .ex_valid_i          (valid_q),
    .ex_mem_read_i       (mem_read_q),
    .ex_write_register_i (wr_q),
    .id_valid_i          (i_id_valid),
    .id_uses_rs_i        (i_id_uses_rs),
    .id_rs_i             (i_id_rs),
    .id_uses_rt_i        (i_id_uses_rt),
    .id_rt_i             (i_id_rt),
    .flush_i             (i_flush),
    .stall_ext_i         (i_stall_ext),
    .load_use_stall_o    (o_load_use_stall),
    .pc_write_o          (o_pc_write),
    .if_id_write_o       (o_if_id_write)
  );

  assign bubble = i_flush || o_load_use_stall;

  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rs_data_d    = rs_data_q;
    rt_data_d    = rt_data_q;
    imm_d        = imm_q;
    alu_op_d     = alu_op_q;
    alu_src_d    = alu_src_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    wr_d         = wr_q;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!i_stall_ext) begin
      if (bubble) begin
        valid_d      = 1'b0;
        pc_d         = '0;
        rs_d         = '0;
        rt_d         = '0;
        rs_data_d    = '0;
        rt_data_d    = '0;
        imm_d        = '0;
        alu_op_d     = '0;
        alu_src_d    = 1'b0;
        reg_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        wr_d         = '0;
        bubble_cnt_d = sat_inc(bubble_cnt_q);
        if (o_load_use_stall) stall_cnt_d = sat_inc(stall_cnt_q);
      end else begin
        valid_d      = i_id_valid;
        pc_d         = i_id_pc;
        rs_d         = i_id_rs;
        rt_d         = i_id_rt;
        rs_data_d    = i_id_rs_data;
        rt_data_d    = i_id_rt_data;
        imm_d        = i_id_imm;
        alu_op_d     = i_id_alu_op;
        alu_src_d    = i_id_alu_src;
        reg_write_d  = i_id_reg_write && i_id_valid;
        mem_read_d   = i_id_mem_read && i_id_valid;
        mem_write_d  = i_id_mem_write && i_id_valid;
        mem_to_reg_d = i_id_mem_to_reg && i_id_valid;
        wr_d         = resolve_wr(i_id_reg_dst, i_id_rt, i_id_rd, i_id_reg_write && i_id_valid);
      end
    end
  end

  // ID -> EX boundary
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      alu_op_q     <= '0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      wr_q         <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      alu_op_q     <= alu_op_d;
      alu_src_q    <= alu_src_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      wr_q         <= wr_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign o_ex_valid          = valid_q;
  assign o_ex_pc             = pc_q;
  assign o_ex_rs             = rs_q;
  assign o_ex_rt             = rt_q;
  assign o_ex_rs_data        = rs_data_q;
  assign o_ex_rt_data        = rt_data_q;
  assign o_ex_imm            = imm_q;
  assign o_ex_alu_op         = alu_op_q;
  assign o_ex_alu_src        = alu_src_q;
  assign o_ex_reg_write      = reg_write_q;
  assign o_ex_mem_read       = mem_read_q;
  assign o_ex_mem_write      = mem_write_q;
  assign o_ex_mem_to_reg     = mem_to_reg_q;
  assign o_ex_write_register = wr_q;
  assign o_stall_count       = stall_cnt_q;
  assign o_bubble_count      = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboarded bench for id_ex_stage: a reference model predicts each EX state
// when stimulus is applied; the prediction is popped and compared after the edge.
module tb_id_ex_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall_ext, flush, id_valid, uses_rs, uses_rt, alu_src;
  logic        reg_write, mem_read, mem_write, mem_to_reg;
  logic [31:0] id_pc, rs_data, rt_data, imm;
  logic [4:0]  rs, rt, rd;
  logic [3:0]  alu_op;
  logic [1:0]  reg_dst;

  logic        o_ex_valid, o_ex_alu_src, o_ex_reg_write, o_ex_mem_read, o_ex_mem_write, o_ex_mem_to_reg;
  logic [31:0] o_ex_pc, o_ex_rs_data, o_ex_rt_data, o_ex_imm, o_stall_count, o_bubble_count;
  logic [4:0]  o_ex_rs, o_ex_rt, o_ex_write_register;
  logic [3:0]  o_ex_alu_op;
  logic        o_load_use_stall, o_pc_write, o_if_id_write;

  logic        s_valid, s_alu_src, s_reg_write, s_mem_read, s_mem_write, s_mem_to_reg;
  logic [31:0] s_pc, s_rs_data, s_rt_data, s_imm;
  logic [4:0]  s_rs, s_rt, s_wr;
  logic [3:0]  s_alu_op, s_sc, s_bc;
  logic        s_stall, s_pcw, s_ifw;

  id_ex_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall_ext(stall_ext), .i_flush(flush),
    .i_id_valid(id_valid), .i_id_pc(id_pc), .i_id_rs(rs), .i_id_rt(rt), .i_id_rd(rd),
    .i_id_uses_rs(uses_rs), .i_id_uses_rt(uses_rt), .i_id_rs_data(rs_data),
    .i_id_rt_data(rt_data), .i_id_imm(imm), .i_id_alu_op(alu_op), .i_id_alu_src(alu_src),
    .i_id_reg_dst(reg_dst), .i_id_reg_write(reg_write), .i_id_mem_read(mem_read),
    .i_id_mem_write(mem_write), .i_id_mem_to_reg(mem_to_reg),
    .o_ex_valid(o_ex_valid), .o_ex_pc(o_ex_pc), .o_ex_rs(o_ex_rs), .o_ex_rt(o_ex_rt),
    .o_ex_rs_data(o_ex_rs_data), .o_ex_rt_data(o_ex_rt_data), .o_ex_imm(o_ex_imm),
    .o_ex_alu_op(o_ex_alu_op), .o_ex_alu_src(o_ex_alu_src), .o_ex_reg_write(o_ex_reg_write),
    .o_ex_mem_read(o_ex_mem_read), .o_ex_mem_write(o_ex_mem_write),
    .o_ex_mem_to_reg(o_ex_mem_to_reg), .o_ex_write_register(o_ex_write_register),
    .o_load_use_stall(o_load_use_stall), .o_pc_write(o_pc_write), .o_if_id_write(o_if_id_write),
    .o_stall_count(o_stall_count), .o_bubble_count(o_bubble_count)
  );

  id_ex_stage #(.CNT_W(4)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall_ext(stall_ext), .i_flush(flush),
    .i_id_valid(id_valid), .i_id_pc(id_pc), .i_id_rs(rs), .i_id_rt(rt), .i_id_rd(rd),
    .i_id_uses_rs(uses_rs), .i_id_uses_rt(uses_rt), .i_id_rs_data(rs_data),
    .i_id_rt_data(rt_data), .i_id_imm(imm), .i_id_alu_op(alu_op), .i_id_alu_src(alu_src),
    .i_id_reg_dst(reg_dst), .i_id_reg_write(reg_write), .i_id_mem_read(mem_read),
    .i_id_mem_write(mem_write), .i_id_mem_to_reg(mem_to_reg),
    .o_ex_valid(s_valid), .o_ex_pc(s_pc), .o_ex_rs(s_rs), .o_ex_rt(s_rt),
    .o_ex_rs_data(s_rs_data), .o_ex_rt_data(s_rt_data), .o_ex_imm(s_imm),
    .o_ex_alu_op(s_alu_op), .o_ex_alu_src(s_alu_src), .o_ex_reg_write(s_reg_write),
    .o_ex_mem_read(s_mem_read), .o_ex_mem_write(s_mem_write),
    .o_ex_mem_to_reg(s_mem_to_reg), .o_ex_write_register(s_wr),
    .o_load_use_stall(s_stall), .o_pc_write(s_pcw), .o_if_id_write(s_ifw),
    .o_stall_count(s_sc), .o_bubble_count(s_bc)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs, rt, wr;
    logic [31:0] rsd, rtd, imm;
    logic [3:0]  op;
    logic        asrc, rw, mr, mw, m2r;
    logic [31:0] sc, bc;
  } ex_t;

  ex_t m_cur;
  ex_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  function automatic ex_t dut_ex();
    ex_t a;
    a.valid = o_ex_valid;   a.pc  = o_ex_pc;      a.rs  = o_ex_rs;      a.rt = o_ex_rt;
    a.wr    = o_ex_write_register;                a.rsd = o_ex_rs_data; a.rtd = o_ex_rt_data;
    a.imm   = o_ex_imm;     a.op  = o_ex_alu_op;  a.asrc = o_ex_alu_src;
    a.rw    = o_ex_reg_write; a.mr = o_ex_mem_read; a.mw = o_ex_mem_write; a.m2r = o_ex_mem_to_reg;
    a.sc    = o_stall_count;  a.bc = o_bubble_count;
    return a;
  endfunction

  function automatic logic model_haz();
    return m_cur.valid && m_cur.mr && (m_cur.wr != 5'd0) && id_valid &&
           ((uses_rs && rs == m_cur.wr) || (uses_rt && rt == m_cur.wr));
  endfunction

  function automatic ex_t predict();
    ex_t n = m_cur;
    logic stl;
    stl = model_haz() && !flush;
    if (stall_ext) return m_cur;
    if (flush || stl) begin
      n = '0;
      n.sc = stl ? m_cur.sc + 1 : m_cur.sc;
      n.bc = m_cur.bc + 1;
    end else begin
      n.valid = id_valid; n.pc = id_pc; n.rs = rs; n.rt = rt;
      n.rsd = rs_data; n.rtd = rt_data; n.imm = imm; n.op = alu_op; n.asrc = alu_src;
      n.rw = reg_write & id_valid; n.mr = mem_read & id_valid;
      n.mw = mem_write & id_valid; n.m2r = mem_to_reg & id_valid;
      if (!(reg_write && id_valid)) n.wr = 5'd0;
      else if (reg_dst == 2'b01)    n.wr = rd;
      else if (reg_dst == 2'b10)    n.wr = 5'd31;
      else                          n.wr = rt;
    end
    return n;
  endfunction

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] a_rs, a_rt, a_rd,
                        input logic urs, urt, input logic [31:0] rsd, rtd, im,
                        input logic [3:0] op, input logic asrc, input logic [1:0] dst,
                        input logic rw, mr, mw, m2r);
    id_valid = v; id_pc = pc; rs = a_rs; rt = a_rt; rd = a_rd; uses_rs = urs; uses_rt = urt;
    rs_data = rsd; rt_data = rtd; imm = im; alu_op = op; alu_src = asrc; reg_dst = dst;
    reg_write = rw; mem_read = mr; mem_write = mw; mem_to_reg = m2r;
  endtask

  // Called away from the edge; checks hazard outputs, pushes a prediction, then scores it.
  task automatic step();
    ex_t e;
    logic es;
    #1;
    es = model_haz() && !flush;
    checks++;
    if (o_load_use_stall !== es)
      $display("FAIL stall: got %b want %b", o_load_use_stall, es);
    checks++;
    if (o_pc_write !== (!stall_ext && !es) || o_if_id_write !== (!stall_ext && !es)) begin
      errors++;
      $display("FAIL pc_write: got %b/%b want %b", o_pc_write, o_if_id_write, !stall_ext && !es);
    end
    if (o_load_use_stall !== es) errors++;
    exp_q.push_back(predict());
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (dut_ex() !== e) begin
      errors++;
      $display("FAIL ex_state: got %h want %h", dut_ex(), e);
    end
    m_cur = e;
  endtask

  task automatic test_reset();
    set_id(1, 32'h100, 5'd1, 5'd2, 5'd3, 1, 1, 32'hAA, 32'hBB, 32'h4, ALU_ADD, 0, REG_DST_RD, 1, 0, 0, 0);
    step();
    set_id(1, 32'h104, 5'd4, 5'd5, 5'd6, 1, 1, 32'h11, 32'h22, 32'h8, ALU_SUB, 1, REG_DST_RT, 1, 1, 0, 1);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_ex() !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h want 0", dut_ex());
    end
    m_cur = '0;
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (dut_ex() !== '0 || s_bc !== 4'd0 || s_sc !== 4'd0) begin
      errors++;
      $display("FAIL reset_release: got %h sat %h/%h want 0", dut_ex(), s_sc, s_bc);
    end
  endtask

  task automatic test_load_use();
    logic [31:0] sc0, bc0;
    sc0 = m_cur.sc; bc0 = m_cur.bc;
    set_id(1, 32'h200, 5'd1, 5'd8, 5'd0, 1, 0, 32'h0, 32'h0, 32'h10, ALU_ADD, 1, REG_DST_RT, 1, 1, 0, 1);
    step();
    set_id(1, 32'h204, 5'd8, 5'd9, 5'd10, 1, 1, 32'h5, 32'h6, 32'h0, ALU_ADD, 0, REG_DST_RD, 1, 0, 0, 0);
    #1;
    checks++;
    if (o_load_use_stall !== 1'b1 || o_pc_write !== 1'b0) begin
      errors++;
      $display("FAIL lu_flag: got stall=%b pcw=%b want 1/0", o_load_use_stall, o_pc_write);
    end
    step();
    checks++;
    if (o_ex_valid !== 1'b0 || o_ex_reg_write !== 1'b0 || o_ex_write_register !== 5'd0 ||
        o_stall_count !== sc0 + 1 || o_bubble_count !== bc0 + 1) begin
      errors++;
      $display("FAIL lu_bubble: got v=%b rw=%b wr=%0d sc=%0d bc=%0d want 0 0 0 %0d %0d",
               o_ex_valid, o_ex_reg_write, o_ex_write_register, o_stall_count, o_bubble_count,
               sc0 + 1, bc0 + 1);
    end
    step();
    checks++;
    if (o_ex_valid !== 1'b1 || o_ex_rs !== 5'd8 || o_ex_write_register !== 5'd10) begin
      errors++;
      $display("FAIL lu_replay: got v=%b rs=%0d wr=%0d want 1 8 10", o_ex_valid, o_ex_rs, o_ex_write_register);
    end
  endtask

  task automatic test_no_false_hazard();
    set_id(1, 32'h300, 5'd2, 5'd0, 5'd0, 1, 0, 32'h0, 32'h0, 32'h0, ALU_ADD, 1, REG_DST_RT, 1, 1, 0, 1);
    step();
    set_id(1, 32'h304, 5'd0, 5'd7, 5'd11, 1, 1, 32'h1, 32'h2, 32'h0, ALU_OR, 0, REG_DST_RD, 1, 0, 0, 0);
    #1;
    checks++;
    if (o_load_use_stall !== 1'b0) begin
      errors++;
      $display("FAIL lw_r0: got stall=%b want 0", o_load_use_stall);
    end
    step();
    set_id(1, 32'h308, 5'd1, 5'd8, 5'd0, 1, 0, 32'h0, 32'h0, 32'h0, ALU_ADD, 1, REG_DST_RT, 1, 1, 0, 1);
    step();
    set_id(1, 32'h30C, 5'd3, 5'd8, 5'd12, 1, 0, 32'h3, 32'h4, 32'h0, ALU_AND, 0, REG_DST_RD, 1, 0, 0, 0);
    #1;
    checks++;
    if (o_load_use_stall !== 1'b0) begin
      errors++;
      $display("FAIL rt_unused: got stall=%b want 0", o_load_use_stall);
    end
    step();
  endtask

  task automatic test_flush();
    logic [31:0] sc0, bc0;
    set_id(1, 32'h400, 5'd1, 5'd8, 5'd0, 1, 0, 32'h0, 32'h0, 32'h0, ALU_ADD, 1, REG_DST_RT, 1, 1, 0, 1);
    step();
    sc0 = m_cur.sc; bc0 = m_cur.bc;
    set_id(1, 32'h404, 5'd8, 5'd9, 5'd10, 1, 1, 32'h5, 32'h6, 32'h0, ALU_ADD, 0, REG_DST_RD, 1, 0, 0, 0);
    flush = 1'b1;
    #1;
    checks++;
    if (o_load_use_stall !== 1'b0 || o_pc_write !== 1'b1) begin
      errors++;
      $display("FAIL flush_flag: got stall=%b pcw=%b want 0/1", o_load_use_stall, o_pc_write);
    end
    step();
    flush = 1'b0;
    checks++;
    if (o_ex_valid !== 1'b0 || o_bubble_count !== bc0 + 1 || o_stall_count !== sc0) begin
      errors++;
      $display("FAIL flush_bubble: got v=%b sc=%0d bc=%0d want 0 %0d %0d",
               o_ex_valid, o_stall_count, o_bubble_count, sc0, bc0 + 1);
    end
  endtask

  task automatic test_ext_stall();
    ex_t snap;
    set_id(1, 32'h500, 5'd4, 5'd5, 5'd6, 1, 1, 32'h77, 32'h88, 32'h9, ALU_XOR, 0, REG_DST_RD, 1, 0, 0, 0);
    step();
    snap = m_cur;
    stall_ext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 32'h600 + 32'(i), 5'(i), 5'(i + 1), 5'(i + 2), 1, 1, 32'(i), 32'(i * 3), 32'h0,
             ALU_SLT, 1, REG_DST_RD, 1, 1, 1, 1);
      #1;
      checks++;
      if (o_pc_write !== 1'b0) begin
        errors++;
        $display("FAIL ext_pcw: got %b want 0", o_pc_write);
      end
      step();
      checks++;
      if (dut_ex() !== snap) begin
        errors++;
        $display("FAIL ext_hold: got %h want %h", dut_ex(), snap);
      end
    end
    stall_ext = 1'b0;
  endtask

  task automatic test_reg_dst();
    set_id(1, 32'h700, 5'd1, 5'd2, 5'd3, 0, 0, 32'h0, 32'h0, 32'h0, ALU_ADD, 1, REG_DST_RA, 1, 0, 0, 0);
    step();
    checks++;
    if (o_ex_write_register !== 5'd31) begin
      errors++;
      $display("FAIL dst_ra: got %0d want 31", o_ex_write_register);
    end
    set_id(1, 32'h704, 5'd1, 5'd2, 5'd3, 1, 1, 32'h0, 32'h0, 32'h0, ALU_ADD, 0, REG_DST_RD, 0, 0, 1, 0);
    step();
    checks++;
    if (o_ex_write_register !== 5'd0) begin
      errors++;
      $display("FAIL dst_norw: got %0d want 0", o_ex_write_register);
    end
    set_id(1, 32'h708, 5'd1, 5'd2, 5'd3, 1, 1, 32'h0, 32'h0, 32'h0, ALU_ADD, 0, 2'b11, 1, 0, 0, 0);
    step();
    checks++;
    if (o_ex_write_register !== 5'd2) begin
      errors++;
      $display("FAIL dst_rsvd: got %0d want 2", o_ex_write_register);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      set_id(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
             4'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      flush     = ($urandom_range(0, 5) == 0);
      stall_ext = ($urandom_range(0, 5) == 0);
      step();
    end
    flush = 1'b0; stall_ext = 1'b0;
  endtask

  task automatic test_saturation();
    flush = 1'b1;
    for (int i = 0; i < 18; i++) step();
    flush = 1'b0;
    checks++;
    if (s_bc !== 4'hF) begin
      errors++;
      $display("FAIL sat_bubble: got %0d want 15", s_bc);
    end
    step();
    checks++;
    if (s_bc !== 4'hF) begin
      errors++;
      $display("FAIL sat_hold: got %0d want 15", s_bc);
    end
  endtask

  initial begin
    rst_n = 1'b0; stall_ext = 1'b0; flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_cur = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_ex() !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h want 0", dut_ex());
    end
    rst_n = 1'b1;
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_flush();
    test_ext_stall();
    test_reg_dst();
    test_back_to_back();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
